// File: rtl/bsg_fpu_i2f_seq_e_p5_m_p10.sv
// bsg_fpu_i2f_seq_e_p5_m_p10
//   Sequential 16-bit integer to IEEE-754 binary16 converter. The magnitude
//   is normalised one left shift per cycle. It is then rounded to nearest-even
//   and packed into {sign, exp[4:0], man[9:0]}. There is one operation in
//   flight, with valid/ready on the input side and valid/yumi on the output.
//
// Ports
//   clk_i       clock
//   reset_i     synchronous active-high reset; aborts any operation
//   a_i         integer operand
//   signed_i    1: a_i is two's complement, 0: a_i is unsigned
//   v_i         operand valid
//   ready_o     block can accept an operand (IDLE only, low during reset)
//   z_o         binary16 result
//   inexact_o   result was rounded
//   overflow_o  result rounded up to infinity
//   v_o         result valid
//   yumi_i      consumer takes the result (only meaningful while v_o=1)
module bsg_fpu_i2f_seq_e_p5_m_p10 #(
  parameter int e_p     = 5,
  parameter int m_p     = 10,
  parameter int width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] a_i,
  input  logic               signed_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [e_p+m_p:0]   z_o,
  output logic               inexact_o,
  output logic               overflow_o,
  output logic               v_o,
  input  logic               yumi_i
);

  localparam int bias_lp = (1 << (e_p - 1)) - 1;
  // The MSB of the magnitude sits at 2^(width_p-1), so the exponent starts there.
  localparam logic [e_p-1:0] exp_init_lp = e_p'(bias_lp + width_p - 1);
  localparam logic [e_p:0]   exp_max_lp  = (e_p+1)'((1 << e_p) - 1);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_e;

  state_e             state_q;
  logic [width_p-1:0] mag_q;
  logic [e_p-1:0]     exp_q;
  logic               sign_q;
  logic [e_p+m_p:0]   z_q;
  logic               inexact_q;
  logic               overflow_q;
  logic               v_q;

  // Operand capture: the magnitude of -32768 is 0x8000, which still fits.
  logic               sign_in;
  logic [width_p-1:0] mag_in;

  assign sign_in = signed_i & a_i[width_p-1];
  assign mag_in  = sign_in ? (~a_i + {{(width_p-1){1'b0}}, 1'b1}) : a_i;

  // Rounding datapath. It is evaluated from the normalised magnitude while in ROUND.
  logic [m_p-1:0]   man;
  logic             guard;
  logic             sticky;
  logic             round_up;
  logic [m_p:0]     man_sum;
  logic [e_p:0]     exp_rnd;
  logic [e_p+m_p:0] z_rnd;
  logic             inexact_rnd;
  logic             overflow_rnd;

  // NOTE: always_comb uses blocking assignments and gives every output a
  // default first, so no path can leave a value held and infer a latch.
  always_comb begin
    man          = mag_q[width_p-2 -: m_p];
    guard        = mag_q[width_p-2-m_p];
    sticky       = |mag_q[width_p-3-m_p:0];
    round_up     = guard & (sticky | man[0]);
    // A carry out of the mantissa leaves man_sum[m_p-1:0] at zero, which is
    // the cleared mantissa. The carry then bumps the exponent.
    man_sum      = {1'b0, man} + {{m_p{1'b0}}, round_up};
    exp_rnd      = {1'b0, exp_q} + {{e_p{1'b0}}, man_sum[m_p]};
    z_rnd        = '0;
    inexact_rnd  = 1'b0;
    overflow_rnd = 1'b0;
    if (mag_q == '0) begin
      // Zero is always +0 with no flags.
      z_rnd = '0;
    end else if (exp_rnd >= exp_max_lp) begin
      z_rnd        = {sign_q, {e_p{1'b1}}, {m_p{1'b0}}};
      inexact_rnd  = 1'b1;
      overflow_rnd = 1'b1;
    end else begin
      z_rnd       = {sign_q, exp_rnd[e_p-1:0], man_sum[m_p-1:0]};
      inexact_rnd = guard | sticky;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      // NOTE: mag_q, exp_q and sign_q are left out of reset on purpose.
      // They are always loaded on accept before anything reads them.
      state_q    <= IDLE;
      z_q        <= '0;
      inexact_q  <= 1'b0;
      overflow_q <= 1'b0;
      v_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (v_i) begin
            sign_q  <= sign_in;
            mag_q   <= mag_in;
            exp_q   <= exp_init_lp;
            state_q <= NORM;
          end
        end
        NORM: begin
          // Zero stays put and goes straight to ROUND. Its exponent is unused.
          if ((mag_q == '0) || mag_q[width_p-1]) begin
            state_q <= ROUND;
          end else begin
            mag_q <= mag_q << 1;
            exp_q <= exp_q - 1'b1;
          end
        end
        ROUND: begin
          z_q        <= z_rnd;
          inexact_q  <= inexact_rnd;
          overflow_q <= overflow_rnd;
          v_q        <= 1'b1;
          state_q    <= DONE;
        end
        DONE: begin
          if (yumi_i) begin
            v_q     <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ready_o is gated by reset_i. It stays low while reset is held and is high
  // in the first cycle after reset releases, because the state is then IDLE.
  assign ready_o    = (state_q == IDLE) & ~reset_i;
  assign z_o        = z_q;
  assign inexact_o  = inexact_q;
  assign overflow_o = overflow_q;
  assign v_o        = v_q;

endmodule

// File: tb/tb_bsg_fpu_i2f_seq_e_p5_m_p10.sv
// tb_bsg_fpu_i2f_seq_e_p5_m_p10
//   Scoreboard bench for the sequential int-to-binary16 converter. The driver
//   pushes the expected result of each accepted operand, with its accept
//   cycle, onto a queue. The monitor pops an entry when v_o rises and checks
//   the value, flags and latency. It then holds off yumi_i for a random time
//   and checks that the outputs stay stable while it waits. Expected values
//   come from spec constants or from an arithmetic RNE model.
module tb_bsg_fpu_i2f_seq_e_p5_m_p10;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [15:0] a_i = '0;
  logic        signed_i = 1'b0;
  logic        v_i = 1'b0;
  logic        yumi_i = 1'b0;
  logic        ready_o;
  logic [15:0] z_o;
  logic        inexact_o;
  logic        overflow_o;
  logic        v_o;

  always #5 clk = ~clk;

  bsg_fpu_i2f_seq_e_p5_m_p10 dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .a_i        (a_i),
    .signed_i   (signed_i),
    .v_i        (v_i),
    .ready_o    (ready_o),
    .z_o        (z_o),
    .inexact_o  (inexact_o),
    .overflow_o (overflow_o),
    .v_o        (v_o),
    .yumi_i     (yumi_i)
  );

  typedef struct {
    logic [15:0] z;
    bit          inx;
    bit          ovf;
    int          lat;
    int          k0;
  } item_t;

  item_t sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  int    n_acc    = 0;
  int    n_done   = 0;
  bit    holding  = 1'b0;
  int    hold_min = 0;
  int    hold_max = 0;
  bit    idle_yumi_req = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic item_t mk(input logic [15:0] z, input bit inx, input bit ovf, input int lat);
    item_t r;
    r.z = z; r.inx = inx; r.ovf = ovf; r.lat = lat; r.k0 = 0;
    return r;
  endfunction

  // Reference: take the exact integer magnitude, find its binary exponent and
  // keep 11 significant bits, rounding to nearest with ties to even.
  function automatic item_t ref_model(input logic [15:0] a, input bit sgn);
    item_t r;
    int v, e, q, rem, half, sh, biased;
    bit s;
    r.k0 = 0; r.ovf = 0; r.inx = 0;
    s = sgn && a[15];
    v = s ? (65536 - int'({16'h0, a})) : int'({16'h0, a});
    if (v == 0) begin
      r.z = 16'h0000; r.lat = 3;
      return r;
    end
    e = 0;
    while ((1 << (e + 1)) <= v) e++;
    r.lat = (15 - e) + 3;
    rem = 0;
    if (e <= 10) begin
      q = v << (10 - e);
    end else begin
      sh   = e - 10;
      q    = v >> sh;
      rem  = v - (q << sh);
      half = 1 << (sh - 1);
      if (rem > half || (rem == half && (q % 2) == 1)) q++;
    end
    if (q == 2048) begin
      q = 1024; e++;
    end
    biased = e + 15;
    r.inx  = (rem != 0);
    if (biased >= 31) begin
      r.z = {s, 5'h1F, 10'h000}; r.ovf = 1; r.inx = 1;
    end else begin
      r.z = {s, 5'(biased), 10'(q - 1024)};
    end
    return r;
  endfunction

  // Monitor: owns yumi_i, pops and checks results, and holds each result
  // for a random number of cycles.
  initial begin
    item_t cur;
    int    hold_left;
    hold_left = 0;
    forever begin
      @(negedge clk);
      if (yumi_i) begin
        yumi_i = 1'b0;
        if (holding) begin
          holding = 1'b0;
          check("after_yumi_v_ready", {30'h0, v_o, ready_o}, 32'h1);
        end
      end else if (holding) begin
        check("hold_stable", {12'h0, v_o, ready_o, overflow_o, inexact_o, z_o},
              {12'h0, 1'b1, 1'b0, cur.ovf, cur.inx, cur.z});
        if (hold_left == 0) yumi_i = 1'b1;
        else hold_left--;
      end else if (v_o) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL v_o_without_accept: actual z=%0h required no result (cycle %0d)", z_o, cyc);
          yumi_i = 1'b1;
        end else begin
          cur = sb.pop_front();
          n_done++;
          check("z", {16'h0, z_o}, {16'h0, cur.z});
          check("inexact", {31'h0, inexact_o}, {31'h0, cur.inx});
          check("overflow", {31'h0, overflow_o}, {31'h0, cur.ovf});
          check("latency", cyc - cur.k0, cur.lat);
          holding   = 1'b1;
          hold_left = int'($urandom_range(hold_max, hold_min));
          if (hold_left == 0) yumi_i = 1'b1;
          else hold_left--;
        end
      end else if (idle_yumi_req) begin
        idle_yumi_req = 1'b0;
        yumi_i = 1'b1;
      end
    end
  end

  // Wait for ready, present one operand for one cycle and push its expected
  // result. With junk set, keep v_i high with random data while the block is busy.
  task automatic issue(input logic [15:0] a, input bit sgn, input item_t exp_item, input bit junk);
    bit got;
    got = 1'b0;
    for (int t = 0; t < 300 && !got; t++) begin
      @(negedge clk);
      if (ready_o) got = 1'b1;
    end
    if (!got) begin
      check("ready_timeout", 32'h0, 32'h1);
      return;
    end
    a_i = a; signed_i = sgn; v_i = 1'b1;
    exp_item.k0 = cyc;
    sb.push_back(exp_item);
    n_acc++;
    @(negedge clk);
    v_i = 1'b0;
    a_i = 16'($urandom);
    signed_i = 1'($urandom);
    if (junk) begin
      for (int t = 0; t < 300; t++) begin
        if (ready_o) break;
        v_i = 1'b1;
        a_i = 16'($urandom);
        signed_i = 1'($urandom);
        @(negedge clk);
      end
      v_i = 1'b0;
    end
  endtask

  task automatic drain();
    bit idle;
    idle = 1'b0;
    for (int t = 0; t < 500 && !idle; t++) begin
      @(negedge clk);
      if (sb.size() == 0 && !holding && !yumi_i) idle = 1'b1;
    end
    if (!idle) check("drain_timeout", sb.size(), 0);
  endtask

  typedef struct {
    logic [15:0] a;
    bit          sgn;
    logic [15:0] z;
    bit          inx;
    bit          ovf;
    int          lat;
  } vec_t;

  vec_t dir[] = '{
    '{16'h0001, 1'b0, 16'h3C00, 1'b0, 1'b0, 18},
    '{16'hFFFF, 1'b1, 16'hBC00, 1'b0, 1'b0, 18},
    '{16'h8000, 1'b1, 16'hF800, 1'b0, 1'b0, 3},
    '{16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 3},
    '{16'h0801, 1'b0, 16'h6800, 1'b1, 1'b0, 7},
    '{16'h0803, 1'b0, 16'h6802, 1'b1, 1'b0, 7},
    '{16'hFFEF, 1'b0, 16'h7BFF, 1'b1, 1'b0, 3},
    '{16'hFFE0, 1'b0, 16'h7BFF, 1'b0, 1'b0, 3},
    '{16'hFFF0, 1'b0, 16'h7C00, 1'b1, 1'b1, 3},
    '{16'hFFFF, 1'b0, 16'h7C00, 1'b1, 1'b1, 3}
  };

  initial begin
    // Outputs while reset is held.
    repeat (3) @(negedge clk);
    check("reset_ready", {31'h0, ready_o}, 32'h0);
    check("reset_v", {31'h0, v_o}, 32'h0);
    check("reset_z", {16'h0, z_o}, 32'h0);
    check("reset_flags", {30'h0, inexact_o, overflow_o}, 32'h0);
    reset_i = 1'b0;
    #1 check("ready_after_reset", {31'h0, ready_o}, 32'h1);

    // Abort: accept unsigned 1, then assert reset in the 5th NORM cycle.
    @(negedge clk);
    a_i = 16'h0001; signed_i = 1'b0; v_i = 1'b1;
    @(negedge clk);
    v_i = 1'b0;
    repeat (4) @(negedge clk);
    reset_i = 1'b1;
    #1 check("abort_ready_in_reset", {31'h0, ready_o}, 32'h0);
    @(negedge clk);
    reset_i = 1'b0;
    #1 check("abort_ready_after", {31'h0, ready_o}, 32'h1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("abort_no_v", {31'h0, v_o}, 32'h0);
    end
    issue(16'h0001, 1'b0, mk(16'h3C00, 1'b0, 1'b0, 18), 1'b0);
    drain();

    // Spec vectors with short random yumi delays.
    hold_min = 0; hold_max = 2;
    foreach (dir[i]) issue(dir[i].a, dir[i].sgn, mk(dir[i].z, dir[i].inx, dir[i].ovf, dir[i].lat), 1'b0);
    drain();

    // Hold the result for 10 cycles while v_i is pulsed with junk.
    hold_min = 10; hold_max = 10;
    issue(16'h0803, 1'b0, mk(16'h6802, 1'b1, 1'b0, 7), 1'b1);
    drain();

    // A yumi pulse in IDLE does nothing. A zero follows it and must come out as +0.
    hold_min = 0; hold_max = 0;
    idle_yumi_req = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_yumi_v_ready", {30'h0, v_o, ready_o}, 32'h1);
    issue(16'h0000, 1'b1, mk(16'h0000, 1'b0, 1'b0, 3), 1'b0);
    drain();

    // Random stream against the arithmetic model.
    hold_min = 0; hold_max = 4;
    for (int i = 0; i < 500; i++) begin
      logic [15:0] a;
      bit          sgn;
      int          mode;
      sgn  = 1'($urandom);
      mode = int'($urandom_range(3, 0));
      case (mode)
        0:       a = 16'($urandom);
        1:       a = 16'($urandom & ((32'h1 << $urandom_range(16, 0)) - 1));
        2:       a = 16'hFFE0 | 16'($urandom_range(31, 0));
        default: a = 16'h8000 ^ 16'($urandom_range(63, 0));
      endcase
      issue(a, sgn, ref_model(a, sgn), ($urandom_range(7, 0) == 0));
    end
    drain();
    check("results_per_accept", n_done, n_acc);
    check("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bsg_fpu_i2f_seq_e_p5_m_p10.md
Name: bsg_fpu_i2f_seq_e_p5_m_p10

Overview:
- Multi-cycle integer-to-half-precision converter with handshakes on both sides.
- Accepts a 16-bit signed or unsigned integer and produces an IEEE-754 binary16 value (e=5, m=10). Rounding is round-to-nearest-even, with inexact and overflow flags.
- This is the packing direction of the FP16 datapath: the FP16 preprocess/compare logic unpacks and classifies floats, and this block composes one from an integer.
- Sits on the integer-to-FP path of the half-precision FPU. Normalizes iteratively with one shift per cycle to keep area small.

Parameters:
- e_p, 5, exponent width. Fixed; other values are unsupported.
- m_p, 10, mantissa width. Fixed.
- width_p, 16, integer input width. Fixed.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- a_i  in  16  integer operand
- signed_i  in  1  1 = a_i is two's complement; 0 = a_i is unsigned
- v_i  in  1  input valid
- ready_o  out  1  block can accept an input (high only in IDLE)
- z_o  out  16  FP16 result {sign, exp[4:0], man[9:0]}
- inexact_o  out  1  result was rounded
- overflow_o  out  1  result rounded up to infinity
- v_o  out  1  result valid
- yumi_i  in  1  consumer takes the result; legal only while v_o=1

Behaviour:

One clock, synchronous active-high reset. There is a single in-flight operation; inputs are not pipelined.

States: IDLE, NORM, ROUND, DONE.

Reset:
- State goes to IDLE; z_o=0, inexact_o=0, overflow_o=0, v_o=0.
- ready_o=0 while reset_i=1 and 1 in the first cycle after reset_i falls.
- reset_i asserted in any state aborts the operation the same cycle. No output is produced for it.

IDLE:
- ready_o=1.
- On v_i&ready_o, capture sign = signed_i & a_i[15] and mag = sign ? (~a_i+1) : a_i, as 16-bit unsigned. -32768 gives mag=0x8000.
- Set exp=30. Bit 15 set corresponds to biased exponent 15+15.
- Next state NORM.

NORM:
- If mag==0, go to ROUND and flag zero.
- Else if mag[15]=1, go to ROUND.
- Else mag<<=1, exp-=1, stay in NORM.
- NORM lasts lz+1 cycles, where lz is the leading-zero count of mag (lz=0 for zero).

ROUND (1 cycle):
- man=mag[14:5], g=mag[4], s=|mag[3:0].
- Round up if g & (s | man[0]). A mantissa carry-out clears man and increments exp.
- If exp>=31 after rounding: z={sign,5'h1F,10'h0}, overflow=1, inexact=1.
- Otherwise z={sign,exp,man}, inexact=g|s.
- Zero: z=16'h0000, flags 0. There is no -0, and no denormal output is possible.
- Register z, inexact and overflow; go to DONE.

DONE:
- v_o=1. z_o and the flags are held stable until yumi_i.
- On yumi_i, go to IDLE. ready_o rises the next cycle, so there is no accept in the same cycle as yumi_i.

Latency:
- Input accepted in cycle c gives v_o first high in cycle c+lz+3.
- Zero input: c+3. Input 1: c+18.

Boundaries:
- yumi_i outside DONE is ignored.
- v_i outside IDLE is ignored; the input is not captured.
- 0xFFFF unsigned overflows to +inf.
- No sticky state persists across operations.

Test Plan:
- Reset mid-operation: accept a_i=0x0001 unsigned, assert reset_i in the 5th NORM cycle. Required: v_o never rises for that operation; ready_o=1 the cycle after reset releases; next operation 0x0001 gives z_o=0x3C00.
- Exact values:
  - unsigned 1 -> 0x3C00, v_o at c+18.
  - signed 0xFFFF (-1) -> 0xBC00.
  - signed 0x8000 -> 0xF800, inexact 0.
  - 0x0000 -> 0x0000, v_o at c+3, flags 0.
- Rounding, unsigned:
  - 2049 (0x0801) -> 0x6800, inexact 1 (tie, even, no round).
  - 2051 (0x0803) -> 0x6802, inexact 1 (tie, odd, rounds up).
  - 65519 (0xFFEF) -> 0x7BFF, inexact 1.
- Overflow, unsigned:
  - 65504 (0xFFE0) -> 0x7BFF, inexact 0.
  - 65520 (0xFFF0) -> 0x7C00, overflow 1, inexact 1.
  - 65535 (0xFFFF) -> 0x7C00, overflow 1.
- Handshake:
  - Hold yumi_i=0 for 10 cycles after v_o: z_o and flags stay stable, ready_o=0.
  - v_i pulsed with a different a_i during NORM/DONE is ignored.
  - yumi_i pulsed in IDLE has no effect.
- Back-to-back stream: random 500 operands, mixed signed_i, random yumi_i delays. Compare every result against a reference model (RNE). Check that exactly one v_o/yumi pair occurs per accepted input and that latency = lz+3.
